// File: rtl/arbitro_prioridade.sv
// N-channel registered priority arbiter: snapshots request profiles, grants the single
// highest-profile requester, holds it until release/drop/timeout and drives tie/winner LEDs.
module arbitro_prioridade #(
  parameter int N_CH     = 4,
  parameter int PERF_W   = 2,
  parameter int HOLD_MAX = 8,
  parameter int TIE_MODE = 0,
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int HOLD_W  = $clog2(HOLD_MAX) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*PERF_W-1:0]   perf,
  input  logic                     release_i,
  output logic [N_CH-1:0]          grant,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     grant_valid,
  output logic                     tie,
  output logic                     timeout,
  output logic                     LED_r,
  output logic                     LED_g,
  output logic                     LED_b
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_GRANT
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [N_CH-1:0]         req_snap;
  logic [N_CH*PERF_W-1:0]  perf_snap;
  logic [IDX_W-1:0]        rr_ptr;
  logic [HOLD_W-1:0]       hold_cnt;

  logic [PERF_W-1:0]       perf_ch [N_CH];
  logic [PERF_W-1:0]       max_perf;
  logic [N_CH-1:0]         at_max;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        rr_next;
  logic                    tie_w;
  logic                    exit_normal;
  logic                    exit_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign perf_ch[gi] = perf_snap[gi*PERF_W +: PERF_W];
      assign at_max[gi]  = req_snap[gi] && (perf_ch[gi] == max_perf);
    end
  endgenerate

  // Profile 0 is still eligible, so starting the max at 0 is safe.
  always_comb begin
    max_perf = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (req_snap[i] && (perf_ch[i] > max_perf)) max_perf = perf_ch[i];
    end
  end

  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = k;
      if (TIE_MODE == 1) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
      end
      if (!found && at_max[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign tie_w        = (at_max & (at_max - 1'b1)) != '0;
  assign rr_next      = (winner == IDX_W'(N_CH - 1)) ? '0 : winner + 1'b1;
  assign exit_normal  = release_i || !req[grant_idx];
  assign exit_timeout = (hold_cnt == HOLD_W'(HOLD_MAX - 1));
  assign grant_valid  = |grant;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req) state_next = ST_ARB;
      ST_ARB:   state_next = ST_GRANT;
      ST_GRANT: if (exit_normal || exit_timeout) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      req_snap  <= '0;
      perf_snap <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      tie       <= 1'b0;
      timeout   <= 1'b0;
      LED_r     <= 1'b0;
      LED_g     <= 1'b0;
      LED_b     <= 1'b0;
    end else begin
      state_reg <= state_next;
      timeout   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            req_snap  <= req;
            perf_snap <= perf;
          end
        end
        ST_ARB: begin
          grant     <= {{(N_CH-1){1'b0}}, 1'b1} << winner;
          grant_idx <= winner;
          tie       <= tie_w;
          LED_g     <= tie_w;
          LED_r     <= !tie_w && (winner != '0);
          LED_b     <= !tie_w && (winner == '0);
          rr_ptr    <= rr_next;
          hold_cnt  <= '0;
        end
        ST_GRANT: begin
          // Release/drop outranks the timeout when both land on the same edge.
          if (exit_normal) begin
            grant     <= '0;
            grant_idx <= '0;
          end else if (exit_timeout) begin
            grant     <= '0;
            grant_idx <= '0;
            timeout   <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_prioridade.sv
// Bench for arbitro_prioridade: one instance per tie mode, scoreboard of expected grants
// pushed at stimulus time and popped when the grant appears.
module tb_arbitro_prioridade;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_s  [2];
  logic [7:0] perf_s [2];
  logic       rel_s  [2];
  logic [3:0] grant_s [2];
  logic [1:0] idx_s  [2];
  logic       gv_s   [2];
  logic       tie_s  [2];
  logic       to_s   [2];
  logic       lr_s   [2];
  logic       lg_s   [2];
  logic       lb_s   [2];

  typedef struct {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       tie;
    logic [2:0] led;
  } exp_t;

  exp_t sb [$];
  int   rr_tb [2];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      arbitro_prioridade #(
        .N_CH(4), .PERF_W(2), .HOLD_MAX(HOLD), .TIE_MODE(gi)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_s[gi]), .perf(perf_s[gi]),
        .release_i(rel_s[gi]), .grant(grant_s[gi]), .grant_idx(idx_s[gi]),
        .grant_valid(gv_s[gi]), .tie(tie_s[gi]), .timeout(to_s[gi]),
        .LED_r(lr_s[gi]), .LED_g(lg_s[gi]), .LED_b(lb_s[gi])
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decision: max profile among requesters, tie count, cyclic scan in mode 1.
  function automatic exp_t model(input int m, input logic [3:0] r, input logic [7:0] p);
    exp_t e;
    int mx = -1;
    int cnt = 0;
    int w = -1;
    int v;
    int i;
    for (int k = 0; k < 4; k++)
      if (r[k]) begin
        v = int'((p >> (2*k)) & 8'h3);
        if (v > mx) mx = v;
      end
    for (int k = 0; k < 4; k++) begin
      i = (m == 1) ? (rr_tb[m] + k) % 4 : k;
      v = int'((p >> (2*i)) & 8'h3);
      if (r[i] && v == mx) begin
        cnt++;
        if (w < 0) w = i;
      end
    end
    rr_tb[m] = (w + 1) % 4;
    e.grant = 4'(1 << w);
    e.idx   = 2'(w);
    e.tie   = (cnt > 1);
    e.led   = e.tie ? 3'b010 : ((w != 0) ? 3'b100 : 3'b001);
    return e;
  endfunction

  task automatic check_cleared(input int m, input string tag);
    check_eq({tag, "_grant"}, grant_s[m], 0);
    check_eq({tag, "_gv"}, gv_s[m], 0);
    check_eq({tag, "_tie"}, tie_s[m], 0);
    check_eq({tag, "_leds"}, {lr_s[m], lg_s[m], lb_s[m]}, 0);
    check_eq({tag, "_timeout"}, to_s[m], 0);
  endtask

  // kind: 0 release after h cycles, 1 drop req after h cycles, 2 hold to timeout, 3 reset mid-grant
  task automatic txn(input int m, input logic [3:0] r, input logic [7:0] p,
                     input int kind, input int h);
    exp_t e;
    int n;
    sb.push_back(model(m, r, p));
    @(negedge clk);
    req_s[m]  = r;
    perf_s[m] = p;
    @(posedge clk); #1;
    check_eq("arb_no_grant_yet", gv_s[m], 0);
    perf_s[m] = ~p;
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq("grant", grant_s[m], e.grant);
    check_eq("grant_idx", idx_s[m], e.idx);
    check_eq("grant_valid", gv_s[m], 1);
    check_eq("tie", tie_s[m], e.tie);
    check_eq("leds_rgb", {lr_s[m], lg_s[m], lb_s[m]}, e.led);
    $display("txn mode=%0d req=%b perf=%h -> grant=%b idx=%0d tie=%0d kind=%0d",
             m, r, p, grant_s[m], idx_s[m], tie_s[m], kind);
    if (kind == 3) begin
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check_cleared(0, "rst_mid0");
      check_cleared(1, "rst_mid1");
      @(posedge clk); #1;
      req_s[m] = '0;
      rst_n    = 1'b1;
      rr_tb[0] = 0;
      rr_tb[1] = 0;
    end else if (kind == 2) begin
      n = 1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (gv_s[m]) n++;
        else break;
      end
      check_eq("hold_cycles", n, HOLD);
      check_eq("timeout_pulse", to_s[m], 1);
      check_eq("timeout_grant", grant_s[m], 0);
      req_s[m] = '0;
      @(posedge clk); #1;
      check_eq("timeout_one_cycle", to_s[m], 0);
    end else begin
      for (int c = 0; c < h; c++) begin
        @(posedge clk); #1;
        check_eq("grant_held", grant_s[m], e.grant);
      end
      @(negedge clk);
      if (kind == 0) rel_s[m] = 1'b1;
      else req_s[m][e.idx] = 1'b0;
      @(posedge clk); #1;
      check_eq("exit_grant", grant_s[m], 0);
      check_eq("exit_no_timeout", to_s[m], 0);
      rel_s[m] = 1'b0;
      req_s[m] = '0;
      @(posedge clk); #1;
      check_eq("idle_after_exit", gv_s[m], 0);
      check_eq("no_late_timeout", to_s[m], 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rr_tb[0] = 0;
    rr_tb[1] = 0;
    for (int m = 0; m < 2; m++) begin
      req_s[m] = '0; perf_s[m] = '0; rel_s[m] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_cleared(0, "reset0");
    check_cleared(1, "reset1");
    @(negedge clk); rst_n = 1'b1;

    // Lowest-index tie mode
    txn(0, 4'b0110, 8'b00_11_10_00, 0, 2);
    txn(0, 4'b1011, 8'b01_00_01_01, 0, 1);
    txn(0, 4'b1011, 8'b01_00_01_01, 0, 0);
    txn(0, 4'b1000, 8'b00_00_00_00, 2, 0);
    txn(0, 4'b0010, 8'b00_00_01_00, 1, 3);
    txn(0, 4'b0001, 8'b00_00_00_10, 0, HOLD - 1);

    // Round-robin tie mode
    for (int t = 0; t < 5; t++) txn(1, 4'b1111, 8'hFF, 0, 1);
    txn(1, 4'b0101, 8'b00_10_00_01, 0, 0);
    txn(1, 4'b1111, 8'hFF, 3, 0);
    txn(1, 4'b1111, 8'hFF, 0, 0);
    txn(1, 4'b1111, 8'hFF, 1, 0);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
